// File: rtl/and_module_pkg.sv
// Shared constants for the and_module block: default operand width and the
// width of the accepted-pair counter.
package and_module_pkg;

  localparam int AND_DEFAULT_WIDTH = 1;
  localparam int AND_CNT_WIDTH     = 16;

endpackage : and_module_pkg

// File: rtl/and_module_pipe_reg.sv
// One-entry valid/ready output register. Accepts a word when the slot is
// empty or being drained in the same cycle, so it sustains one word per
// cycle under continuous flow. Synchronous active-high reset drops any
// pending word and holds in_ready low.
module and_module_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic accept;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Slot update: load on accept, clear on drain, hold under back-pressure.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : and_module_pipe_reg

// File: rtl/and_module.sv
// Bitwise AND with a combinational result z and a registered, valid/ready
// handshaked copy z_q, plus a wrapping 16-bit count of accepted pairs.
// Optional feature macro: AND_MODULE_REDUCE_EN adds z_all (AND-reduction of
// a & b) and z_all_q (its registered copy, stored alongside z_q).
module and_module
  import and_module_pkg::*;
#(
  parameter int WIDTH = AND_DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         z,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         z_q,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef AND_MODULE_REDUCE_EN
  output logic                     z_all,
  output logic                     z_all_q,
`endif
  output logic [AND_CNT_WIDTH-1:0] acc_count
);

`ifdef AND_MODULE_REDUCE_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif

  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;
  logic          accept;

  // The combinational path ignores clock, reset and handshake entirely.
  assign z      = a & b;
  assign accept = in_valid && in_ready;

`ifdef AND_MODULE_REDUCE_EN
  assign z_all   = &z;
  assign pipe_in = {z_all, z};
  assign z_q     = pipe_out[WIDTH-1:0];
  assign z_all_q = pipe_out[WIDTH];
`else
  assign pipe_in = z;
  assign z_q     = pipe_out;
`endif

  and_module_pipe_reg #(
    .W (PW)
  ) u_pipe_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pipe_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pipe_out)
  );

  // Accepted-pair counter; wraps naturally at 2**AND_CNT_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count <= '0;
    end else if (accept) begin
      acc_count <= acc_count + 1'b1;
    end
  end

endmodule : and_module

// File: tb/tb_and_module.sv
// Self-checking bench for and_module: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_and_module;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, z, z_q;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [15:0]  acc_count;
`ifdef AND_MODULE_REDUCE_EN
  logic         z_all, z_all_q;
  logic         n_z_all, n_z_all_q;
`endif

  // Narrow instance used only for the combinational truth table.
  logic         a1, b1, z1, n_zq1, n_ir1, n_ov1;
  logic [15:0]  n_cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model: pending results in a queue (at most one deep), plus count.
  logic [W-1:0] exp_q[$];
  int unsigned  exp_cnt = 0;

  always #5 clk = ~clk;

  and_module #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .z         (z),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_q       (z_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AND_MODULE_REDUCE_EN
    .z_all     (z_all),
    .z_all_q   (z_all_q),
`endif
    .acc_count (acc_count)
  );

  and_module #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (1'b1),
    .a         (a1),
    .b         (b1),
    .z         (z1),
    .in_valid  (1'b0),
    .in_ready  (n_ir1),
    .z_q       (n_zq1),
    .out_valid (n_ov1),
    .out_ready (1'b0),
`ifdef AND_MODULE_REDUCE_EN
    .z_all     (n_z_all),
    .z_all_q   (n_z_all_q),
`endif
    .acc_count (n_cnt1)
  );

  function automatic logic exp_in_ready();
    return !rst && (exp_q.size() == 0 || out_ready);
  endfunction

  task automatic drive(input logic r, input logic iv, input logic ordy,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    a         = aa;
    b         = bb;
    #1;
  endtask

  // Advance the model by the rules for this edge, then pass the edge.
  task automatic tick();
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      bit acc;
      acc = in_valid && exp_in_ready();
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(a & b);
        exp_cnt = (exp_cnt + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom));
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_comb: got %b want 0", in_ready); end
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (z_q !== 8'h00) begin bad++; $display("FAIL reset_z_q: got %h want 00", z_q); end
    total++; if (acc_count !== 16'h0000) begin bad++; $display("FAIL reset_acc_count: got %h want 0000", acc_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
`ifdef AND_MODULE_REDUCE_EN
    total++; if (z_all_q !== 1'b0) begin bad++; $display("FAIL reset_z_all_q: got %b want 0", z_all_q); end
`endif
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_comb();
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      #10;
      total++; if (z1 !== (i == 3)) begin bad++; $display("FAIL comb_w1_%0d: got %b want %b", i, z1, (i == 3)); end
    end
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      a  = ra;
      b  = rb;
      #1;
      total++; if (z !== (ra & rb)) begin bad++; $display("FAIL comb_w8_%0d: got %h want %h", i, z, ra & rb); end
    end
    tick();
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 1'b1, 8'hF0, 8'h3C);
    total++; if (z !== 8'h30) begin bad++; $display("FAIL single_z: got %h want 30", z); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    total++; if (z_q !== 8'h30) begin bad++; $display("FAIL single_z_q: got %h want 30", z_q); end
    total++; if (acc_count !== 16'd1) begin bad++; $display("FAIL single_acc_count: got %0d want 1", acc_count); end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int unsigned base;
    base = exp_cnt;
    drive(1'b0, 1'b1, 1'b0, 8'hA5, 8'h0F);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready); end
      tick();
      total++; if (z_q !== 8'h05) begin bad++; $display("FAIL bp_z_q_%0d: got %h want 05", k, z_q); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid_%0d: got %b want 1", k, out_valid); end
      total++; if (acc_count !== 16'(base + 1)) begin bad++; $display("FAIL bp_acc_%0d: got %0d want %0d", k, acc_count, base + 1); end
    end
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    total++; if (z_q !== 8'hFF) begin bad++; $display("FAIL bp_swap_z_q: got %h want ff", z_q); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_swap_valid: got %b want 1", out_valid); end
    total++; if (acc_count !== 16'(base + 2)) begin bad++; $display("FAIL bp_swap_acc: got %0d want %0d", acc_count, base + 2); end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [W-1:0] sa[4] = '{8'h12, 8'hFF, 8'h81, 8'h7E};
    logic [W-1:0] sb[4] = '{8'h36, 8'hA5, 8'hC3, 8'h3C};
    int unsigned base;
    base = exp_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, sa[i], sb[i]);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid_%0d: got %b want 1", i, out_valid); end
      total++; if (z_q !== (sa[i] & sb[i])) begin bad++; $display("FAIL stream_z_q_%0d: got %h want %h", i, z_q, sa[i] & sb[i]); end
      total++; if (acc_count !== 16'(base + i + 1)) begin bad++; $display("FAIL stream_acc_%0d: got %0d want %0d", i, acc_count, base + i + 1); end
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(39, 0) == 0), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      total++; if (in_ready !== exp_in_ready()) begin bad++; $display("FAIL rand_in_ready_%0d: got %b want %b", i, in_ready, exp_in_ready()); end
      total++; if (z !== (a & b)) begin bad++; $display("FAIL rand_z_%0d: got %h want %h", i, z, a & b); end
`ifdef AND_MODULE_REDUCE_EN
      total++; if (z_all !== (a == 8'hFF && b == 8'hFF)) begin bad++; $display("FAIL rand_z_all_%0d: got %b", i, z_all); end
`endif
      tick();
      total++; if (out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rand_out_valid_%0d: got %b want %b", i, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        total++; if (z_q !== exp_q[0]) begin bad++; $display("FAIL rand_z_q_%0d: got %h want %h", i, z_q, exp_q[0]); end
`ifdef AND_MODULE_REDUCE_EN
        total++; if (z_all_q !== (exp_q[0] == 8'hFF)) begin bad++; $display("FAIL rand_z_all_q_%0d: got %b", i, z_all_q); end
`endif
      end
      total++; if (acc_count !== 16'(exp_cnt)) begin bad++; $display("FAIL rand_acc_%0d: got %0d want %0d", i, acc_count, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 8'hC3, 8'hFF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pending: got %b want 1", out_valid); end
    drive(1'b1, 1'b1, 1'b1, 8'h5A, 8'h0F);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    total++; if (z !== 8'h0A) begin bad++; $display("FAIL rmid_z: got %h want 0a", z); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    total++; if (z_q !== 8'h00) begin bad++; $display("FAIL rmid_z_q: got %h want 00", z_q); end
    total++; if (acc_count !== 16'h0000) begin bad++; $display("FAIL rmid_acc: got %h want 0000", acc_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready_held: got %b want 0", in_ready); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 65536; i++) begin
      drive(1'b0, 1'b1, 1'b1, W'($urandom), W'($urandom));
      tick();
    end
    total++; if (acc_count !== 16'h0000) begin bad++; $display("FAIL wrap_acc: got %h want 0000", acc_count); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
`ifdef AND_MODULE_REDUCE_EN
    total++; if (z_all !== 1'b1) begin bad++; $display("FAIL reduce_ff: got %b want 1", z_all); end
`endif
    tick();
    total++; if (acc_count !== 16'h0001) begin bad++; $display("FAIL wrap_acc_next: got %h want 0001", acc_count); end
`ifdef AND_MODULE_REDUCE_EN
    total++; if (z_all_q !== 1'b1) begin bad++; $display("FAIL reduce_ff_q: got %b want 1", z_all_q); end
`endif
    drive(1'b0, 1'b1, 1'b1, 8'hFE, 8'hFF);
`ifdef AND_MODULE_REDUCE_EN
    total++; if (z_all !== 1'b0) begin bad++; $display("FAIL reduce_fe: got %b want 0", z_all); end
`endif
    tick();
    total++; if (z_q !== 8'hFE) begin bad++; $display("FAIL wrap_z_q: got %h want fe", z_q); end
`ifdef AND_MODULE_REDUCE_EN
    total++; if (z_all_q !== 1'b0) begin bad++; $display("FAIL reduce_fe_q: got %b want 0", z_all_q); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a1 = 1'b0;
    b1 = 1'b0;
    test_reset();
    test_comb();
    test_single();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_and_module
